clk_div_ctrl: RTL and testbench

Programmable-ratio controller for the synchronous clock divider. It runs a loadable mod-N count and derives a divided clock and a terminal-count tick from it. A valid/ready port accepts new divide ratios and applies them only at a period boundary, so the divided clock never sees a runt pulse. It replaces the fixed mod-10 count path when software must change the division ratio at run time.

---
 rtl/clk_div_pkg.sv | 18 +
 rtl/clk_div_cnt.sv | 45 ++++
 rtl/clk_div_ctrl.sv | 160 ++++++++++++++++
 tb/tb_clk_div_ctrl.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/clk_div_pkg.sv
// Shared types and constants for the programmable clock divider.
package clk_div_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PEND
  } state_e;

  localparam int DIV_W_DEF    = 4;
  localparam int DIV_MIN      = 2;
  localparam int PERIOD_CNT_W = 16;

  function automatic logic div_legal(input logic [31:0] n);
    return n >= 32'(DIV_MIN);
  endfunction

endpackage

// File: rtl/clk_div_cnt.sv
// Loadable mod-N counter: clear wins, wraps from N-1 back to 0.
module clk_div_cnt
  import clk_div_pkg::*;
#(
  parameter int W = DIV_W_DEF
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_clr,
  input  logic         i_en,
  input  logic [W-1:0] i_n,
  output logic [W-1:0] o_count,
  output logic [W-1:0] o_count_nxt,
  output logic         o_wrap
);

  logic [W-1:0] cnt_q, cnt_d;
  logic [W-1:0] last;
  logic         at_last;

  assign last    = i_n - W'(1);
  assign at_last = cnt_q >= last;
  assign o_wrap  = i_en && !i_clr && at_last;

  always_comb begin
    cnt_d = cnt_q;
    if (i_clr) begin
      cnt_d = '0;
    end else if (i_en) begin
      cnt_d = at_last ? '0 : cnt_q + W'(1);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_count     = cnt_q;
  assign o_count_nxt = cnt_d;

endmodule

// File: rtl/clk_div_ctrl.sv
// Run-time programmable divider: ratios apply only at a period boundary.
// Optional wrap counter port o_period_cnt with CLK_DIV_PERIOD_CNT_EN.
module clk_div_ctrl
  import clk_div_pkg::*;
#(
  parameter int DIV_W       = DIV_W_DEF,
  parameter int DEFAULT_DIV = 10
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic             i_cfg_valid,
  input  logic [DIV_W-1:0] i_cfg_div,
  output logic             o_cfg_ready,
  output logic             o_cfg_err,
  output logic [DIV_W-1:0] o_count,
  output logic             o_tick,
  output logic             o_clk_div
`ifdef CLK_DIV_PERIOD_CNT_EN
  ,
  output logic [PERIOD_CNT_W-1:0] o_period_cnt
`endif
);

  state_e           state_q, state_d;
  logic [DIV_W-1:0] ratio_q, ratio_d;
  logic [DIV_W-1:0] pend_q, pend_d;
  logic             rdy_q, rdy_d;
  logic             err_q, err_d;
  logic             tick_q, tick_d;
  logic             clkd_q, clkd_d;

  logic             acc;
  logic             acc_ok;
  logic             apply;
  logic             cnt_clr;
  logic             wrap;
  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] cnt_nxt;

  assign cnt_clr = (state_q == IDLE) || !i_en;

  clk_div_cnt #(
    .W (DIV_W)
  ) u_cnt (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_clr       (cnt_clr),
    .i_en        (i_en),
    .i_n         (ratio_q),
    .o_count     (cnt),
    .o_count_nxt (cnt_nxt),
    .o_wrap      (wrap)
  );

  assign acc    = i_cfg_valid && rdy_q;
  assign acc_ok = acc && div_legal(32'(i_cfg_div));

  always_comb begin
    state_d = state_q;
    ratio_d = ratio_q;
    pend_d  = pend_q;
    apply   = 1'b0;
    err_d   = acc && !acc_ok;
    unique case (state_q)
      IDLE: begin
        if (acc_ok) begin
          ratio_d = i_cfg_div;
          apply   = 1'b1;
        end
        if (i_en) state_d = RUN;
      end
      RUN: begin
        if (!i_en) begin
          state_d = IDLE;
          if (acc_ok) begin
            ratio_d = i_cfg_div;
            apply   = 1'b1;
          end
        end else if (acc_ok) begin
          if (wrap) begin
            ratio_d = i_cfg_div;
            apply   = 1'b1;
          end else begin
            pend_d  = i_cfg_div;
            state_d = PEND;
          end
        end
      end
      PEND: begin
        if (!i_en || wrap) begin
          ratio_d = pend_q;
          apply   = 1'b1;
          state_d = i_en ? RUN : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output decode looks ahead so all three outputs land on the same edge.
  always_comb begin
    rdy_d  = state_d != PEND;
    tick_d = (state_d != IDLE) && (cnt_nxt == ratio_d - DIV_W'(1));
    clkd_d = (state_d != IDLE) && (cnt_nxt < (ratio_d >> 1));
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      ratio_q <= DIV_W'(DEFAULT_DIV);
      pend_q  <= '0;
      rdy_q   <= 1'b1;
      err_q   <= 1'b0;
      tick_q  <= 1'b0;
      clkd_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ratio_q <= ratio_d;
      pend_q  <= pend_d;
      rdy_q   <= rdy_d;
      err_q   <= err_d;
      tick_q  <= tick_d;
      clkd_q  <= clkd_d;
    end
  end

  assign o_cfg_ready = rdy_q;
  assign o_cfg_err   = err_q;
  assign o_count     = cnt;
  assign o_tick      = tick_q;
  assign o_clk_div   = clkd_q;

`ifdef CLK_DIV_PERIOD_CNT_EN
  logic [PERIOD_CNT_W-1:0] per_q, per_d;

  always_comb begin
    per_d = per_q;
    if (apply) begin
      per_d = '0;
    end else if (wrap && per_q != '1) begin
      per_d = per_q + PERIOD_CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      per_q <= '0;
    end else begin
      per_q <= per_d;
    end
  end

  assign o_period_cnt = per_q;
`else
  logic unused_apply;
  assign unused_apply = apply;
`endif

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Directed self-checking bench for clk_div_ctrl.
module tb_clk_div_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic       valid = 1'b0;
  logic [3:0] div = 4'd0;
  logic       rdy;
  logic       err;
  logic [3:0] cnt;
  logic       tick;
  logic       clkd;
`ifdef CLK_DIV_PERIOD_CNT_EN
  logic [15:0] per;
`endif

  int n_run = 0;
  int n_fail = 0;

  bit m_run;
  bit m_pend;
  bit m_err;
  int m_cnt;
  int m_n;
  int m_pn;
  int m_per;

  always #5 clk = ~clk;

  clk_div_ctrl dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_en         (en),
    .i_cfg_valid  (valid),
    .i_cfg_div    (div),
    .o_cfg_ready  (rdy),
    .o_cfg_err    (err),
    .o_count      (cnt),
    .o_tick       (tick),
    .o_clk_div    (clkd)
`ifdef CLK_DIV_PERIOD_CNT_EN
    ,
    .o_period_cnt (per)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp,
               $time);
    end
  endtask

  task automatic model_reset();
    m_run  = 0;
    m_pend = 0;
    m_err  = 0;
    m_cnt  = 0;
    m_n    = 10;
    m_pn   = 0;
    m_per  = 0;
  endtask

  task automatic cyc();
    bit e;
    e = en;
    @(posedge clk);
    #1;
    if (!m_run) begin
      m_cnt = 0;
      m_run = e;
    end else if (!e) begin
      m_run = 0;
      m_cnt = 0;
      if (m_pend) begin
        m_n = m_pn;
        m_pend = 0;
        m_per = 0;
      end
    end else if (m_cnt == m_n - 1) begin
      m_cnt = 0;
      if (m_per < 65535) m_per++;
      if (m_pend) begin
        m_n = m_pn;
        m_pend = 0;
        m_per = 0;
      end
    end else begin
      m_cnt++;
    end
  endtask

  task automatic outs();
    check("count", cnt, m_cnt);
    check("tick", tick, m_run && m_cnt == m_n - 1);
    check("clk_div", clkd, m_run && m_cnt < m_n / 2);
    check("ready", rdy, !m_pend);
    check("err", err, m_err);
`ifdef CLK_DIV_PERIOD_CNT_EN
    check("period", per, m_per);
`endif
  endtask

  task automatic run(input int k);
    repeat (k) begin
      cyc();
      outs();
    end
  endtask

  task automatic wait_cnt(input int v);
    int i = 0;
    while (cnt != v && i < 40) begin
      cyc();
      outs();
      i++;
    end
    check("wait_cnt", cnt, v);
  endtask

  task automatic offer(input int d);
    valid = 1'b1;
    div = 4'(d);
    cyc();
    valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    en = 1'b0;
    valid = 1'b0;
    #2;
    model_reset();
    outs();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #1;
    do_reset();

    // default ratio 10
    en = 1'b1;
    run(25);

    // ratio 5 offered mid-period
    wait_cnt(3);
    offer(5);
    m_pend = 1;
    m_pn = 5;
    outs();
    run(20);

    // ratio 6 offered on the wrap cycle
    do_reset();
    en = 1'b1;
    wait_cnt(9);
    offer(6);
    m_n = 6;
    m_per = 0;
    outs();
    run(13);

    // enable dropped on a wrap, then ratio set in IDLE
    wait_cnt(5);
    en = 1'b0;
    cyc();
    outs();
    offer(7);
    m_n = 7;
    m_per = 0;
    outs();
    en = 1'b1;
    run(16);

    // illegal ratios
    do_reset();
    en = 1'b1;
    run(3);
    offer(1);
    m_err = 1;
    outs();
    m_err = 0;
    run(2);
    offer(0);
    m_err = 1;
    outs();
    m_err = 0;
    run(22);

    // async reset while a ratio is pending
    do_reset();
    en = 1'b1;
    wait_cnt(3);
    offer(5);
    m_pend = 1;
    m_pn = 5;
    outs();
    wait_cnt(6);
    #2;
    do_reset();
    en = 1'b1;
    run(25);

    // period counter
    do_reset();
    en = 1'b1;
    run(31);
`ifdef CLK_DIV_PERIOD_CNT_EN
    check("period_3", per, 3);
`endif
    wait_cnt(3);
    offer(4);
    m_pend = 1;
    m_pn = 4;
    outs();
    wait_cnt(0);
`ifdef CLK_DIV_PERIOD_CNT_EN
    check("period_clr", per, 0);
`endif
    run(8);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
